// File: rtl/nvram_upload_responder_pkg.sv
// rtl/nvram_upload_responder_pkg.sv - shared state encoding and save-slot defaults
package nvram_upload_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2,
        ST_DONE  = 2'd3
    } upload_state_e;

    // Also the save index advertised in the core's CONF_STR.
    localparam logic [7:0] DEFAULT_UPLOAD_INDEX = 8'd4;

endpackage

// File: rtl/nvram_upload_responder_ioctl_read_pipe.sv
// rtl/nvram_upload_responder_ioctl_read_pipe.sv - 2-stage ioctl read pipeline with out-of-range zero fill
module ioctl_read_pipe #(
    parameter int ADDR_W = 12,
    parameter int LENGTH = 4096
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_en,
    input  logic [24:0]       rd_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic [7:0]        dout
);

    localparam logic [24:0] LIMIT = 25'(LENGTH);

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_rd_q, ram_rd_d;
    logic              oor1_q, oor1_d;
    logic              fill_q, fill_d;
    logic              oor2_q, oor2_d;
    logic [7:0]        dout_q, dout_d;

    // The range test uses the full 25-bit address so aliases above LENGTH read as zero.
    always_comb begin
        ram_addr_d = ram_addr_q;
        oor1_d     = oor1_q;
        ram_rd_d   = rd_en;
        if (rd_en) begin
            ram_addr_d = rd_addr[ADDR_W-1:0];
            oor1_d     = (rd_addr >= LIMIT);
        end
        fill_d = ram_rd_q;
        oor2_d = oor1_q;
        dout_d = dout_q;
        if (fill_q) begin
            dout_d = oor2_q ? 8'h00 : ram_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ram_addr_q <= '0;
            ram_rd_q   <= 1'b0;
            oor1_q     <= 1'b0;
            fill_q     <= 1'b0;
            oor2_q     <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_rd_q   <= ram_rd_d;
            oor1_q     <= oor1_d;
            fill_q     <= fill_d;
            oor2_q     <= oor2_d;
            dout_q     <= dout_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_rd   = ram_rd_q;
    assign dout     = dout_q;

endmodule

// File: rtl/nvram_upload_responder.sv
// rtl/nvram_upload_responder.sv - dirty tracking, save request and ioctl upload serving for NVRAM
module nvram_upload_responder
    import nvram_upload_responder_pkg::*;
#(
    parameter int          ADDR_W       = 12,
    parameter int          LENGTH       = 4096,
    parameter logic [7:0]  UPLOAD_INDEX = DEFAULT_UPLOAD_INDEX,
    parameter logic [23:0] REQ_TIMEOUT  = 24'd4_900_000
) (
    input  logic              clk_49m,
    input  logic              reset,
    input  logic              save_trigger,
    input  logic              ram_we_snoop,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_upload_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic              pause_cpu,
    output logic              dirty
);

    upload_state_e state_q, state_d;
    logic          req_q, req_d;
    logic          pause_q, pause_d;
    logic          dirty_q, dirty_d;
    logic [23:0]   cnt_q, cnt_d;
    logic          match;

    assign match = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pause_d = pause_q;
        cnt_d   = cnt_q;
        dirty_d = dirty_q | ram_we_snoop;
        case (state_q)
            ST_IDLE: begin
                // HPS-initiated saves are served even without a pending request.
                if (match) begin
                    state_d = ST_SERVE;
                    pause_d = 1'b1;
                end else if (save_trigger && dirty_q) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    pause_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (match) begin
                    state_d = ST_SERVE;
                    req_d   = 1'b0;
                end else if (cnt_q == REQ_TIMEOUT) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    pause_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_SERVE: begin
                if (!ioctl_upload) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                pause_d = 1'b0;
                dirty_d = ram_we_snoop;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_49m) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            pause_q <= 1'b0;
            dirty_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pause_q <= pause_d;
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
        end
    end

    ioctl_read_pipe #(
        .ADDR_W (ADDR_W),
        .LENGTH (LENGTH)
    ) u_read_pipe (
        .clk      (clk_49m),
        .resetn   (reset),
        .rd_en    (ioctl_rd && (state_q == ST_SERVE)),
        .rd_addr  (ioctl_addr),
        .ram_addr (ram_addr),
        .ram_rd   (ram_rd),
        .ram_data (ram_data),
        .dout     (ioctl_din)
    );

    assign ioctl_upload_req = req_q;
    assign pause_cpu        = pause_q;
    assign dirty            = dirty_q;

endmodule

// File: tb/tb_nvram_upload_responder.sv
// tb/tb_nvram_upload_responder.sv - scoreboard bench for nvram_upload_responder
module tb_nvram_upload_responder;

    localparam int LENGTH = 4096;
    localparam int TMO    = 300;

    logic        clk_49m = 1'b0;
    logic        reset = 1'b0;
    logic        save_trigger = 1'b0;
    logic        ram_we_snoop = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic [11:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_data = 8'h00;
    logic        pause_cpu;
    logic        dirty;

    nvram_upload_responder #(
        .ADDR_W      (12),
        .LENGTH      (LENGTH),
        .UPLOAD_INDEX(8'd4),
        .REQ_TIMEOUT (24'(TMO))
    ) dut (
        .clk_49m         (clk_49m),
        .reset           (reset),
        .save_trigger    (save_trigger),
        .ram_we_snoop    (ram_we_snoop),
        .ioctl_upload    (ioctl_upload),
        .ioctl_rd        (ioctl_rd),
        .ioctl_addr      (ioctl_addr),
        .ioctl_index     (ioctl_index),
        .ioctl_din       (ioctl_din),
        .ioctl_upload_req(ioctl_upload_req),
        .ram_addr        (ram_addr),
        .ram_rd          (ram_rd),
        .ram_data        (ram_data),
        .pause_cpu       (pause_cpu),
        .dirty           (dirty)
    );

    always #5 clk_49m = ~clk_49m;

    logic [7:0] mem [0:4095];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [7:0]  val;
        logic [24:0] addr;
    } exp_t;
    exp_t sbq[$];

    always @(posedge clk_49m) cyc <= cyc + 1;
    always @(posedge clk_49m) if (ram_rd) ram_data <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [24:0] a);
        logic [11:0] idx;
        idx = a[11:0];
        return (a >= 25'(LENGTH)) ? 8'h00 : mem[idx];
    endfunction

    always @(posedge clk_49m) begin : monitor
        exp_t e;
        #2;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk($sformatf("ioctl_din@0x%0h", e.addr), {24'd0, ioctl_din}, {24'd0, e.val});
        end
    end

    task automatic tick();
        @(posedge clk_49m);
        #1;
    endtask

    task automatic issue_rd(input logic [24:0] a);
        exp_t e;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        e.due  = cyc + 3;
        e.val  = ref_byte(a);
        e.addr = a;
        sbq.push_back(e);
        tick();
        ioctl_rd = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_din"},   {24'd0, ioctl_din}, 32'd0);
        chk({tag, "_req"},   {31'd0, ioctl_upload_req}, 32'd0);
        chk({tag, "_raddr"}, {20'd0, ram_addr}, 32'd0);
        chk({tag, "_rrd"},   {31'd0, ram_rd}, 32'd0);
        chk({tag, "_pause"}, {31'd0, pause_cpu}, 32'd0);
        chk({tag, "_dirty"}, {31'd0, dirty}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 200000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'hA5;
        mem[12'h000] = 8'h3C;

        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Trigger without dirty is ignored
        save_trigger = 1'b1; tick(); save_trigger = 1'b0;
        chk("clean_trigger_req", {31'd0, ioctl_upload_req}, 32'd0);
        tick();
        chk("clean_trigger_pause", {31'd0, pause_cpu}, 32'd0);

        // Reads outside SERVE do nothing
        ioctl_addr = 25'h10; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        chk("idle_rd_ignored", {31'd0, ram_rd}, 32'd0);

        ram_we_snoop = 1'b1; tick(); ram_we_snoop = 1'b0;
        chk("snoop_sets_dirty", {31'd0, dirty}, 32'd1);
        save_trigger = 1'b1; tick(); save_trigger = 1'b0;
        chk("trigger_req", {31'd0, ioctl_upload_req}, 32'd1);
        chk("trigger_pause", {31'd0, pause_cpu}, 32'd1);

        ioctl_upload = 1'b1; ioctl_index = 8'd3;
        repeat (3) tick();
        chk("mismatch_req_held", {31'd0, ioctl_upload_req}, 32'd1);
        ioctl_index = 8'd4;
        tick();
        chk("match_req_drop", {31'd0, ioctl_upload_req}, 32'd0);
        chk("serve_pause", {31'd0, pause_cpu}, 32'd1);

        issue_rd(25'h010);
        chk("ram_rd_pulse", {31'd0, ram_rd}, 32'd1);
        chk("ram_addr_cap", {20'd0, ram_addr}, 32'h010);
        repeat (3) tick();
        issue_rd(25'h000);
        repeat (3) tick();
        issue_rd(25'h1000);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) issue_rd(25'(i));
        repeat (3) tick();
        issue_rd(25'd4095);
        issue_rd(25'd4096);
        for (int i = 0; i < 24; i++) begin
            issue_rd(25'($urandom_range(0, 8191)));
            if ($urandom_range(0, 2) == 0) tick();
        end
        repeat (4) tick();

        ioctl_upload = 1'b0; tick();
        chk("done_pause_held", {31'd0, pause_cpu}, 32'd1);
        tick();
        chk("after_done_pause", {31'd0, pause_cpu}, 32'd0);
        chk("after_done_dirty", {31'd0, dirty}, 32'd0);

        // HPS-initiated upload; snoop write during DONE keeps dirty
        ioctl_upload = 1'b1; tick();
        chk("hps_init_pause", {31'd0, pause_cpu}, 32'd1);
        issue_rd(25'h020);
        repeat (3) tick();
        ioctl_upload = 1'b0; tick();
        ram_we_snoop = 1'b1; tick(); ram_we_snoop = 1'b0;
        chk("done_snoop_dirty", {31'd0, dirty}, 32'd1);
        chk("done_snoop_pause", {31'd0, pause_cpu}, 32'd0);

        // Request timeout
        save_trigger = 1'b1; tick(); save_trigger = 1'b0;
        chk("tmo_req_start", {31'd0, ioctl_upload_req}, 32'd1);
        repeat (TMO - 2) tick();
        chk("tmo_req_not_early", {31'd0, ioctl_upload_req}, 32'd1);
        w = 0;
        while (ioctl_upload_req && w < 10) begin
            tick();
            w++;
        end
        chk("tmo_req_exit", {31'd0, ioctl_upload_req}, 32'd0);
        chk("tmo_pause", {31'd0, pause_cpu}, 32'd0);
        chk("tmo_dirty_kept", {31'd0, dirty}, 32'd1);

        // Upload ends in the same cycle as a read
        ioctl_upload = 1'b1; tick();
        ioctl_addr = 25'h123; ioctl_rd = 1'b1; ioctl_upload = 1'b0;
        begin
            exp_t e;
            e.due = cyc + 3; e.val = ref_byte(25'h123); e.addr = 25'h123;
            sbq.push_back(e);
        end
        tick(); ioctl_rd = 1'b0;
        chk("midread_done_pause", {31'd0, pause_cpu}, 32'd1);
        tick();
        chk("midread_idle_pause", {31'd0, pause_cpu}, 32'd0);
        repeat (3) tick();

        // Reset during SERVE
        ioctl_upload = 1'b1; tick();
        issue_rd(25'h010);
        repeat (3) tick();
        ram_we_snoop = 1'b1; tick(); ram_we_snoop = 1'b0;
        reset = 1'b0; ioctl_upload = 1'b0; tick();
        check_all_zero("midreset");
        reset = 1'b1;
        repeat (3) tick();

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
